// File: rtl/rom_dl_pkg.sv
// rom_dl_pkg: shared types and constants for the ROM download scheduler.
//   DL_AW        ioctl byte-address width
//   ST_*         scheduler state encodings (also exported on dbg_state_o)
//   dl_state_e   named view of the same encodings
//   dl_entry_t   one buffered byte write {addr, data}
package rom_dl_pkg;

  localparam int DL_AW = 24;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef enum logic [1:0] {
    INIT = ST_INIT,
    IDLE = ST_IDLE,
    WAIT = ST_WAIT
  } dl_state_e;

  typedef struct packed {
    logic [DL_AW-1:0] addr;
    logic [7:0]       data;
  } dl_entry_t;

endpackage

// File: rtl/rom_dl_sched_if.sv
// rom_dl_sched_if: bundles the ioctl download bus, both SDRAM write ports,
// the BRAM write bus and the status flags of rom_dl_sched.
//   slave  modport: the scheduler's view (drives requests, BRAM bus, status)
//   master modport: the environment's view (drives ioctl and SDRAM acks)
// Optional: ROMDL_CHECKSUM_EN adds dl_sum (16-bit wrapping sum of bytes
// sent to SDRAM).
//
// SDRAM port handshake: a request is issued by toggling portN_req; it is
// complete when portN_ack equals portN_req. A new request is only issued
// once both ports have completed, and a/ds/d/we are held while any port is
// still outstanding.
interface rom_dl_sched_if;
  import rom_dl_pkg::*;

  logic             ioctl_downl;
  logic             ioctl_wr;
  logic [DL_AW-1:0] ioctl_addr;
  logic [7:0]       ioctl_dout;

  logic             port1_req;
  logic             port1_ack;
  logic [22:0]      port1_a;
  logic [1:0]       port1_ds;
  logic [15:0]      port1_d;
  logic             port1_we;

  logic             port2_req;
  logic             port2_ack;
  logic [22:0]      port2_a;
  logic [1:0]       port2_ds;
  logic [15:0]      port2_d;
  logic             port2_we;

  logic             bram_wr;
  logic [15:0]      bram_addr;
  logic [7:0]       bram_data;

  logic             busy;
  logic             rom_loaded;
  logic             overflow;
`ifdef ROMDL_CHECKSUM_EN
  logic [15:0]      dl_sum;
`endif

  modport slave (
    input  ioctl_downl, ioctl_wr, ioctl_addr, ioctl_dout,
    input  port1_ack, port2_ack,
    output port1_req, port1_a, port1_ds, port1_d, port1_we,
    output port2_req, port2_a, port2_ds, port2_d, port2_we,
    output bram_wr, bram_addr, bram_data,
    output busy, rom_loaded, overflow
`ifdef ROMDL_CHECKSUM_EN
    , output dl_sum
`endif
  );

  modport master (
    output ioctl_downl, ioctl_wr, ioctl_addr, ioctl_dout,
    output port1_ack, port2_ack,
    input  port1_req, port1_a, port1_ds, port1_d, port1_we,
    input  port2_req, port2_a, port2_ds, port2_d, port2_we,
    input  bram_wr, bram_addr, bram_data,
    input  busy, rom_loaded, overflow
`ifdef ROMDL_CHECKSUM_EN
    , input dl_sum
`endif
  );

endinterface

// File: rtl/dl_fifo.sv
// dl_fifo: small synchronous FIFO of dl_entry_t with a fall-through head.
//   clk_i, rst_ni  clock, async active-low reset (pointers only)
//   push_i, din_i  write request and entry; ignored when full unless a pop
//                  happens in the same cycle (the pop frees the slot)
//   pop_i          consume head; ignored when empty
//   dout_o         current head entry (valid while !empty_o)
//   full_o/empty_o occupancy flags
// DEPTH must be a power of two, at least 2.
module dl_fifo
  import rom_dl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  dl_entry_t din_i,
  input  logic      pop_i,
  output dl_entry_t dout_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = $clog2(DEPTH);

  dl_entry_t   mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/rom_dl_sched.sv
// rom_dl_sched: schedules ROM download bytes from data_io into the two
// mirrored SDRAM write ports and the on-chip BRAM write bus, in the 48 MHz
// SDRAM clock domain.
//   clk_sys      system/SDRAM clock
//   reset_n      async active-low reset
//   bus          rom_dl_sched_if.slave (ioctl in, SDRAM ports, BRAM bus,
//                busy / rom_loaded / overflow status)
//   dbg_state_o  current scheduler state (ST_INIT/ST_IDLE/ST_WAIT)
// Parameters: FIFO_DEPTH (power of two, >= 2), BRAM_HI (ioctl_addr[23:16]
// value that also writes BRAM).
// Optional: ROMDL_CHECKSUM_EN adds bus.dl_sum, a wrapping sum of the bytes
// popped to SDRAM, cleared when a download starts.
module rom_dl_sched
  import rom_dl_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] BRAM_HI    = 8'h00
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  rom_dl_sched_if.slave bus,
  output logic [1:0]    dbg_state_o
);

  logic [1:0]  state_q, state_d;
  logic        req1_q, req1_d, req2_q, req2_d;
  logic        we_q, we_d;
  logic [22:0] a_q, a_d;
  logic [1:0]  ds_q, ds_d;
  logic [15:0] d_q, d_d;

  logic        wr_last_q, downl_last_q;
  logic        dl_seen_q, dl_seen_d;
  logic        overflow_q, overflow_d;
  logic        rom_loaded_q, rom_loaded_d;
  logic        bram_wr_q, bram_wr_d;
  logic [15:0] bram_addr_q, bram_addr_d;
  logic [7:0]  bram_data_q, bram_data_d;

  logic        wr_edge, downl_rise, pop;
  logic        fifo_full, fifo_empty, acks_done;
  dl_entry_t   push_entry, head;

  // A new byte is a rising strobe while a download is active.
  assign wr_edge    = bus.ioctl_wr && !wr_last_q && bus.ioctl_downl;
  assign downl_rise = bus.ioctl_downl && !downl_last_q;
  assign push_entry = {bus.ioctl_addr, bus.ioctl_dout};
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;
  assign acks_done  = (bus.port1_ack == req1_q) && (bus.port2_ack == req2_q);

  dl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .push_i  (wr_edge),
    .din_i   (push_entry),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    req1_d  = req1_q;
    req2_d  = req2_q;
    we_d    = we_q;
    a_d     = a_q;
    ds_d    = ds_q;
    d_d     = d_q;
    case (state_q)
      // The SDRAM controller is not reset with us; adopt its ack levels so
      // no phantom request appears after reset.
      ST_INIT: begin
        req1_d  = bus.port1_ack;
        req2_d  = bus.port2_ack;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!fifo_empty) begin
          a_d     = head.addr[23:1];
          ds_d    = {head.addr[0], ~head.addr[0]};
          d_d     = {head.data, head.data};
          we_d    = 1'b1;
          req1_d  = ~req1_q;
          req2_d  = ~req2_q;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (acks_done) begin
          we_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    dl_seen_d    = dl_seen_q || bus.ioctl_downl;
    overflow_d   = overflow_q;
    rom_loaded_d = rom_loaded_q;
    bram_wr_d    = wr_edge && (bus.ioctl_addr[23:16] == BRAM_HI);
    bram_addr_d  = bram_addr_q;
    bram_data_d  = bram_data_q;
    if (wr_edge) begin
      bram_addr_d = bus.ioctl_addr[15:0];
      bram_data_d = bus.ioctl_dout;
    end
    if (downl_rise) begin
      overflow_d   = 1'b0;
      rom_loaded_d = 1'b0;
    end else if (!bus.ioctl_downl && (state_q == ST_IDLE) && fifo_empty && dl_seen_q) begin
      rom_loaded_d = 1'b1;
    end
    // Dropped only if no pop frees a slot in the same cycle.
    if (wr_edge && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      req1_q       <= 1'b0;
      req2_q       <= 1'b0;
      we_q         <= 1'b0;
      a_q          <= '0;
      ds_q         <= '0;
      d_q          <= '0;
      wr_last_q    <= 1'b0;
      downl_last_q <= 1'b0;
      dl_seen_q    <= 1'b0;
      overflow_q   <= 1'b0;
      rom_loaded_q <= 1'b0;
      bram_wr_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      req1_q       <= req1_d;
      req2_q       <= req2_d;
      we_q         <= we_d;
      a_q          <= a_d;
      ds_q         <= ds_d;
      d_q          <= d_d;
      wr_last_q    <= bus.ioctl_wr;
      downl_last_q <= bus.ioctl_downl;
      dl_seen_q    <= dl_seen_d;
      overflow_q   <= overflow_d;
      rom_loaded_q <= rom_loaded_d;
      bram_wr_q    <= bram_wr_d;
      bram_addr_q  <= bram_addr_d;
      bram_data_q  <= bram_data_d;
    end
  end

`ifdef ROMDL_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (downl_rise)  sum_d = '0;
    else if (pop)    sum_d = sum_q + {8'h00, head.data};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) sum_q <= '0;
    else          sum_q <= sum_d;
  end

  assign bus.dl_sum = sum_q;
`endif

  // Both ports carry the same write; port2 mirrors port1.
  assign bus.port1_req  = req1_q;
  assign bus.port1_a    = a_q;
  assign bus.port1_ds   = ds_q;
  assign bus.port1_d    = d_q;
  assign bus.port1_we   = we_q;
  assign bus.port2_req  = req2_q;
  assign bus.port2_a    = a_q;
  assign bus.port2_ds   = ds_q;
  assign bus.port2_d    = d_q;
  assign bus.port2_we   = we_q;
  assign bus.bram_wr    = bram_wr_q;
  assign bus.bram_addr  = bram_addr_q;
  assign bus.bram_data  = bram_data_q;
  assign bus.busy       = !fifo_empty || (state_q != ST_IDLE);
  assign bus.rom_loaded = rom_loaded_q;
  assign bus.overflow   = overflow_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_rom_dl_sched.sv
// tb_rom_dl_sched: directed scenarios plus a randomized download for
// rom_dl_sched. Expected SDRAM writes and BRAM pulses are queued by the
// driver when a byte is strobed and consumed by monitors in order.
module tb_rom_dl_sched;
  import rom_dl_pkg::*;

  localparam int         DEPTH   = 4;
  localparam logic [7:0] BRAM_HI = 8'h00;

  // ---------------- clock / reset ----------------
  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] dbg_state;

  always #10 clk_sys = ~clk_sys;

  rom_dl_sched_if bus();

  rom_dl_sched #(.FIFO_DEPTH(DEPTH), .BRAM_HI(BRAM_HI)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];       // {addr24, data8} expected SDRAM writes
  logic [23:0] bram_exp_q[$];  // {addr16, data8} expected BRAM pulses
  logic [15:0] sum_exp = '0;
  int n_tests = 0;
  int n_fail  = 0;
  int txn_cnt = 0;
  int stab_bad = 0;

  logic p1_ack = 1'b0, p2_ack = 1'b0;
  bit   resp_en = 1'b0;
  bit   mon_en  = 1'b1;
  int   lat1 = 3, lat2 = 3;

  assign bus.port1_ack = p1_ack;
  assign bus.port2_ack = p2_ack;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- SDRAM responders ----------------
  initial begin : resp1
    forever begin
      @(posedge clk_sys); #1;
      if (resp_en && reset_n && bus.port1_req != p1_ack) begin : serve1
        int l;
        l = lat1;
        repeat (l - 1) @(posedge clk_sys);
        #1 p1_ack = bus.port1_req;
      end
    end
  end

  initial begin : resp2
    forever begin
      @(posedge clk_sys); #1;
      if (resp_en && reset_n && bus.port2_req != p2_ack) begin : serve2
        int l;
        l = lat2;
        repeat (l - 1) @(posedge clk_sys);
        #1 p2_ack = bus.port2_req;
      end
    end
  end

  // ---------------- monitors ----------------
  logic        p1_prev = 1'b0, p2_prev = 1'b0, out_prev = 1'b0;
  logic [22:0] cur_a;
  logic [1:0]  cur_ds;
  logic [15:0] cur_d;

  always @(negedge clk_sys) begin : mon_txn
    logic [31:0] e;
    if (mon_en && reset_n) begin
      if (bus.port1_req != p1_prev) begin
        txn_cnt++;
        check("txn_port2_toggles", bus.port2_req != p2_prev, 1);
        check("txn_after_both_acks", out_prev, 0);
        if (exp_q.size() == 0) begin
          check("txn_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("txn_fields",
                {bus.port1_a, bus.port1_ds, bus.port1_d,
                 bus.port2_a, bus.port2_ds, bus.port2_d, bus.port1_we, bus.port2_we},
                {e[31:9], e[8], ~e[8], e[7:0], e[7:0],
                 e[31:9], e[8], ~e[8], e[7:0], e[7:0], 2'b11});
        end
        cur_a  = bus.port1_a;
        cur_ds = bus.port1_ds;
        cur_d  = bus.port1_d;
      end else if (bus.port1_req != bus.port1_ack || bus.port2_req != bus.port2_ack) begin
        if (bus.port1_a !== cur_a || bus.port1_ds !== cur_ds || bus.port1_d !== cur_d ||
            bus.port2_a !== cur_a || bus.port2_d !== cur_d || bus.port1_we !== 1'b1)
          stab_bad++;
      end
    end
    p1_prev  = bus.port1_req;
    p2_prev  = bus.port2_req;
    out_prev = (bus.port1_req != bus.port1_ack) || (bus.port2_req != bus.port2_ack);
  end

  always @(negedge clk_sys) begin : mon_bram
    logic [23:0] b;
    if (reset_n && bus.bram_wr) begin
      if (bram_exp_q.size() == 0) begin
        check("bram_unexpected", 1, 0);
      end else begin
        b = bram_exp_q.pop_front();
        check("bram_write", {bus.bram_addr, bus.bram_data}, b);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [23:0] addr, input logic [7:0] data, input bit to_sdram);
    @(posedge clk_sys); #1;
    bus.ioctl_addr = addr;
    bus.ioctl_dout = data;
    bus.ioctl_wr   = 1'b1;
    if (bus.ioctl_downl) begin
      if (addr[23:16] == BRAM_HI) bram_exp_q.push_back({addr[15:0], data});
      if (to_sdram) begin
        exp_q.push_back({addr, data});
        sum_exp += {8'h00, data};
      end
    end
    @(posedge clk_sys); #1;
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(posedge clk_sys); #1;
    while ((bus.busy || bus.port1_req != p1_ack || bus.port2_req != p2_ack) && n < 2000) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check(tag, n < 2000, 1);
  endtask

  task automatic wait_loaded(input string tag);
    int n;
    n = 0;
    while (!bus.rom_loaded && n < 2000) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check(tag, n < 2000, 1);
  endtask

  task automatic downl_rise();
    @(posedge clk_sys); #1;
    bus.ioctl_downl = 1'b1;
    sum_exp = '0;
    @(posedge clk_sys); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, {bus.port1_req, bus.port2_req, bus.port1_we, bus.port2_we}, 4'b0000);
    check({tag, "_a_ds_d"}, {bus.port1_a, bus.port1_ds, bus.port1_d,
                             bus.port2_a, bus.port2_ds, bus.port2_d}, '0);
    check({tag, "_flags"}, {bus.bram_wr, bus.rom_loaded, bus.overflow}, 3'b000);
    check({tag, "_state"}, dbg_state, INIT);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int t0, n;
    logic [7:0]  hi;
    logic [23:0] ra;
    bus.ioctl_downl = 1'b0;
    bus.ioctl_wr    = 1'b0;
    bus.ioctl_addr  = '0;
    bus.ioctl_dout  = '0;

    #5 check_reset_values("reset");
    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    @(posedge clk_sys); #1;
    check("init_req_follow_ack", {bus.port1_req, bus.port2_req}, 2'b00);
    downl_rise();

    // Test 1: single byte, acks echoed by hand 3 cycles after the request.
    send_byte(24'h010003, 8'h5A, 1'b1);
    n = 0;
    while (bus.port1_req == p1_ack && n < 10) begin @(posedge clk_sys); #1; n++; end
    check("t1_req_seen", n < 10, 1);
    check("t1_port1", {bus.port1_a, bus.port1_ds, bus.port1_d, bus.port1_we},
          {23'h008001, 2'b10, 16'h5A5A, 1'b1});
    check("t1_reqs", {bus.port1_req, bus.port2_req}, 2'b11);
    repeat (2) @(posedge clk_sys);
    #1;
    check("t1_busy_before_ack", bus.busy, 1);
    p1_ack = bus.port1_req;
    p2_ack = bus.port2_req;
    @(posedge clk_sys); #1;
    check("t1_busy_after_ack", {bus.busy, bus.port1_we}, 2'b00);
    check("t1_drained", exp_q.size(), 0);
    resp_en = 1'b1;

    // Test 2: BRAM-range byte pulses bram_wr exactly at E+1, SDRAM also written.
    lat1 = 2; lat2 = 2;
    @(posedge clk_sys); #1;
    bus.ioctl_addr = 24'h001234;
    bus.ioctl_dout = 8'h11;
    bus.ioctl_wr   = 1'b1;
    exp_q.push_back({24'h001234, 8'h11});
    bram_exp_q.push_back({16'h1234, 8'h11});
    sum_exp += 16'h0011;
    check("t2_bram_at_E", bus.bram_wr, 0);
    @(posedge clk_sys); #1;
    check("t2_bram_at_E1", {bus.bram_wr, bus.bram_addr, bus.bram_data}, {1'b1, 16'h1234, 8'h11});
    bus.ioctl_wr = 1'b0;
    @(posedge clk_sys); #1;
    check("t2_bram_one_cycle", bus.bram_wr, 0);
    wait_idle("t2_idle");
    check("t2_drained", exp_q.size(), 0);

    // Test 3: acks held off 40 cycles; one byte in flight plus DEPTH queued,
    // the sixth back-to-back byte is dropped.
    lat1 = 40; lat2 = 40;
    t0 = txn_cnt;
    for (int i = 0; i < 5; i++) send_byte(24'h020000 + 24'(i * 2), 8'(8'hA0 + i), 1'b1);
    check("t3_no_overflow_5", bus.overflow, 0);
    send_byte(24'h02000A, 8'hA5, 1'b0);
    check("t3_overflow_6", bus.overflow, 1);
    wait_idle("t3_idle");
    check("t3_txn_count", txn_cnt - t0, 1 + DEPTH);
    check("t3_drained", exp_q.size(), 0);

    // Download end then restart: flags sticky, then cleared by downl rise.
    @(posedge clk_sys); #1;
    bus.ioctl_downl = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("t3_loaded_sticky_ovf", {bus.rom_loaded, bus.overflow}, 2'b11);
    downl_rise();
    check("t3_rise_clears", {bus.rom_loaded, bus.overflow}, 2'b00);

    // Test 4: port2 acks 10 cycles after port1; no early request, stable a/d.
    lat1 = 3; lat2 = 13;
    stab_bad = 0;
    send_byte(24'h030010, 8'h3C, 1'b1);
    send_byte(24'h030011, 8'hC3, 1'b1);
    send_byte(24'h030020, 8'h7E, 1'b1);
    wait_idle("t4_idle");
    check("t4_stable_in_wait", stab_bad, 0);
    check("t4_drained", exp_q.size(), 0);

    // Test 5: downl falls with entries queued; rom_loaded waits for drain.
    lat1 = 8; lat2 = 6;
    for (int i = 0; i < 4; i++) send_byte(24'h040100 + 24'(i), 8'($urandom), 1'b1);
    bus.ioctl_downl = 1'b0;
    @(posedge clk_sys); #1;
    check("t5_not_loaded_yet", bus.rom_loaded, 0);
    wait_loaded("t5_loaded");
    check("t5_drained_at_load", {exp_q.size() == 0, bus.busy,
          bus.port1_req == p1_ack, bus.port2_req == p2_ack}, 4'b1011);
`ifdef ROMDL_CHECKSUM_EN
    check("t5_dl_sum", bus.dl_sum, sum_exp);
`endif
    // Strobes while downl = 0 are ignored.
    t0 = txn_cnt;
    send_byte(24'h000777, 8'h77, 1'b1);
    repeat (10) @(posedge clk_sys);
    #1;
    check("t5_ignored", {txn_cnt - t0, bus.busy, bus.rom_loaded}, {32'd0, 1'b0, 1'b1});
    downl_rise();
    check("t5_rise_clears", bus.rom_loaded, 0);

    // Test 6: reset during WAIT with SDRAM acks left at 1.
    resp_en = 1'b0;
    send_byte(24'h050001, 8'h99, 1'b1);
    n = 0;
    while (bus.port1_req == p1_ack && n < 10) begin @(posedge clk_sys); #1; n++; end
    check("t6_req_seen", n < 10, 1);
    repeat (2) @(posedge clk_sys);
    #1;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1 check_reset_values("t6_reset");
    p1_ack = 1'b1;
    p2_ack = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    sum_exp = '0;
    @(posedge clk_sys); #1;
    check("t6_resync", {bus.port1_req, bus.port2_req}, 2'b11);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_sys); #1;
      if (bus.port1_we || bus.port2_we || !bus.port1_req || !bus.port2_req) n++;
    end
    check("t6_no_spurious", n, 0);
    mon_en  = 1'b1;
    resp_en = 1'b1;

    // Random download: random addresses/data/latencies, spaced so FIFO never fills.
    t0 = txn_cnt;
    for (int i = 0; i < 40; i++) begin
      lat1 = $urandom_range(1, 5);
      lat2 = $urandom_range(1, 5);
      hi = ($urandom_range(0, 1) == 0) ? BRAM_HI : 8'($urandom_range(1, 255));
      ra = {hi, 16'($urandom)};
      send_byte(ra, 8'($urandom), 1'b1);
      repeat ($urandom_range(8, 16)) @(posedge clk_sys);
    end
    #1 bus.ioctl_downl = 1'b0;
    wait_loaded("rnd_loaded");
    check("rnd_txn_count", txn_cnt - t0, 40);
    check("rnd_drained", {exp_q.size(), bram_exp_q.size()}, 64'd0);
    check("rnd_no_overflow", bus.overflow, 0);
`ifdef ROMDL_CHECKSUM_EN
    check("rnd_dl_sum", bus.dl_sum, sum_exp);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
